// File: rtl/iterative_muldiv_pkg.sv
// Shared EXE-stage definitions: command codes, mul/div op encodings and the
// mul/div FSM state encoding, plus small op-decode helpers.
package iterative_muldiv_pkg;

  typedef enum logic [3:0] {
    EXE_NOP    = 4'd0,
    EXE_ALU    = 4'd1,
    EXE_SHIFT  = 4'd2,
    EXE_BRANCH = 4'd3,
    EXE_LOAD   = 4'd4,
    EXE_STORE  = 4'd5,
    EXE_MULDIV = 4'd6,
    EXE_MFHI   = 4'd7,
    EXE_MFLO   = 4'd8,
    EXE_MTHI   = 4'd9,
    EXE_MTLO   = 4'd10
  } exe_cmd_e;

  typedef logic [1:0] muldiv_op_t;

  localparam muldiv_op_t OP_MULTU = 2'b00;
  localparam muldiv_op_t OP_MULT  = 2'b01;
  localparam muldiv_op_t OP_DIVU  = 2'b10;
  localparam muldiv_op_t OP_DIV   = 2'b11;

  typedef logic [1:0] muldiv_state_t;

  localparam muldiv_state_t ST_IDLE = 2'd0;
  localparam muldiv_state_t ST_RUN  = 2'd1;
  localparam muldiv_state_t ST_FIX  = 2'd2;

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/iterative_muldiv_sign_adj.sv
// Combinational sign handling around the unsigned datapath: operand magnitude
// extraction at start, and sign correction of the raw result in FIX.
module muldiv_sign_adj
  import iterative_muldiv_pkg::*;
#(
  parameter int WORD_LEN = 32
) (
  input  logic                signed_op,
  input  logic [WORD_LEN-1:0] src_a,
  input  logic [WORD_LEN-1:0] src_b,
  output logic [WORD_LEN-1:0] mag_a,
  output logic [WORD_LEN-1:0] mag_b,
  output logic                neg_a,
  output logic                neg_b,
  input  logic                res_div,
  input  logic                res_neg_a,
  input  logic                res_neg_b,
  input  logic [WORD_LEN-1:0] raw_hi,
  input  logic [WORD_LEN-1:0] raw_lo,
  output logic [WORD_LEN-1:0] fix_hi,
  output logic [WORD_LEN-1:0] fix_lo
);

  logic [2*WORD_LEN-1:0] prod;
  logic [2*WORD_LEN-1:0] prod_fix;

  assign neg_a = signed_op & src_a[WORD_LEN-1];
  assign neg_b = signed_op & src_b[WORD_LEN-1];
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign mag_a = neg_a ? -src_a : src_a;
  assign mag_b = neg_b ? -src_b : src_b;

  assign prod     = {raw_hi, raw_lo};
  assign prod_fix = (res_neg_a ^ res_neg_b) ? -prod : prod;

  // NOTE: every output of a combinational block gets a value on every path so no latch is inferred.
  always_comb begin
    fix_hi = prod_fix[2*WORD_LEN-1:WORD_LEN];
    fix_lo = prod_fix[WORD_LEN-1:0];
    if (res_div) begin
      // Quotient sign follows the operand signs; remainder follows the dividend.
      fix_lo = (res_neg_a ^ res_neg_b) ? -raw_lo : raw_lo;
      fix_hi = res_neg_a ? -raw_hi : raw_hi;
    end
  end

endmodule

// File: rtl/iterative_muldiv.sv
// Radix-2 iterative multiply/divide unit with HI/LO result registers.
// One shared shift register serves shift-add multiply and restoring divide.
module iterative_muldiv
  import iterative_muldiv_pkg::*;
#(
  parameter int                  WORD_LEN    = 32,
  parameter logic [WORD_LEN-1:0] HI_LO_RESET = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WORD_LEN-1:0] src_a,
  input  logic [WORD_LEN-1:0] src_b,
  input  logic                flush,
  input  logic                hi_wr_en,
  input  logic                lo_wr_en,
  input  logic [WORD_LEN-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic [WORD_LEN-1:0] hi,
  output logic [WORD_LEN-1:0] lo,
  output logic                div_by_zero
);

  localparam int W     = WORD_LEN;
  localparam int SR_W  = 2 * W + 1;
  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic [W-1:0]     a_q, a_d;
  logic             div_q, div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             b_zero_q, b_zero_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             start_signed;
  logic             start_div;
  logic [W-1:0]     mag_a, mag_b;
  logic             neg_a, neg_b;
  logic [W-1:0]     fix_hi, fix_lo;

  logic [W:0]       mul_sum;
  logic [SR_W-1:0]  mul_next;
  logic [W+1:0]     div_trial;
  logic [W:0]       div_diff;
  logic             div_ge;
  logic [W:0]       div_rem;
  logic [SR_W-1:0]  div_next;

  assign start_signed = op_is_signed(op);
  assign start_div    = op_is_div(op);

  muldiv_sign_adj #(
    .WORD_LEN(W)
  ) u_sign_adj (
    .signed_op(start_signed),
    .src_a    (src_a),
    .src_b    (src_b),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .neg_a    (neg_a),
    .neg_b    (neg_b),
    .res_div  (div_q),
    .res_neg_a(neg_a_q),
    .res_neg_b(neg_b_q),
    .raw_hi   (sr_q[2*W-1:W]),
    .raw_lo   (sr_q[W-1:0]),
    .fix_hi   (fix_hi),
    .fix_lo   (fix_lo)
  );

  // Multiply: {carry, accumulator, multiplier}; add multiplicand on LSB, shift right.
  assign mul_sum  = {1'b0, sr_q[2*W-1:W]} + {1'b0, (sr_q[0] ? opnd_q : {W{1'b0}})};
  assign mul_next = {1'b0, mul_sum, sr_q[W-1:1]};

  // Divide: {remainder, dividend/quotient}; shift left, subtract divisor if it fits.
  assign div_trial = sr_q[2*W:W-1];
  assign div_ge    = div_trial >= {2'b00, opnd_q};
  assign div_diff  = div_trial[W:0] - {1'b0, opnd_q};
  assign div_rem   = div_ge ? div_diff : div_trial[W:0];
  assign div_next  = {div_rem, sr_q[W-2:0], div_ge};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    div_d    = div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    b_zero_d = b_zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (hi_wr_en) hi_d = wr_data;
        if (lo_wr_en) lo_d = wr_data;
        if (start && !flush) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          a_d      = src_a;
          div_d    = start_div;
          neg_a_d  = neg_a;
          neg_b_d  = neg_b;
          b_zero_d = (src_b == {W{1'b0}});
          opnd_d   = start_div ? mag_b : mag_a;
          sr_d     = {{(W + 1){1'b0}}, (start_div ? mag_a : mag_b)};
        end
      end

      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          sr_d  = div_q ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (div_q && b_zero_q) begin
            hi_d  = a_q;
            lo_d  = {W{1'b1}};
            dbz_d = 1'b1;
          end else begin
            hi_d  = fix_hi;
            lo_d  = fix_lo;
            dbz_d = 1'b0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      div_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      hi_q     <= HI_LO_RESET;
      lo_q     <= HI_LO_RESET;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      opnd_q   <= opnd_d;
      a_q      <= a_d;
      div_q    <= div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      b_zero_q <= b_zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iterative_muldiv.sv
// Scoreboard bench for iterative_muldiv (WORD_LEN = 32): directed corner cases,
// flush/reset/back-to-back scenarios and randomized ops against an arithmetic model.
module tb_iterative_muldiv;

  localparam int          W       = 32;
  localparam int          LAT     = W + 1;
  localparam logic [31:0] RST_VAL = 32'hA5A5_0F0F;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        hi_wr_en;
  logic        lo_wr_en;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  iterative_muldiv #(
    .WORD_LEN   (W),
    .HI_LO_RESET(RST_VAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .hi_wr_en   (hi_wr_en),
    .lo_wr_en   (lo_wr_en),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model from the architectural definition, using wide plain arithmetic.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rh, output logic [31:0] rl, output logic rz);
    longint sa, sb_, r;
    logic [63:0] u;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    rz  = 1'b0;
    rh  = '0;
    rl  = '0;
    case (o)
      2'b00: begin
        u  = {32'd0, a} * {32'd0, b};
        rh = u[63:32];
        rl = u[31:0];
      end
      2'b01: begin
        r  = sa * sb_;
        u  = r;
        rh = u[63:32];
        rl = u[31:0];
      end
      2'b10: begin
        if (b == 0) begin
          rl = 32'hFFFF_FFFF; rh = a; rz = 1'b1;
        end else begin
          rl = a / b; rh = a % b;
        end
      end
      default: begin
        if (b == 0) begin
          rl = 32'hFFFF_FFFF; rh = a; rz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000; rh = 32'h0;
        end else begin
          r  = sa / sb_; u = r; rl = u[31:0];
          r  = sa % sb_; u = r; rh = u[31:0];
        end
      end
    endcase
  endfunction

  task automatic push_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    ref_model(o, a, b, e.hi, e.lo, e.dbz);
    e.due   = cyc + LAT;
    last_hi = e.hi;
    last_lo = e.lo;
    sb.push_back(e);
  endtask

  // Waits for IDLE, presents one start, confirms acceptance; track=0 for ops that will be aborted.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit track);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("issue_wait_idle", busy, 0);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_accepted", busy, 1);
    if (track) push_exp(o, a, b);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(mon_e.due));
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
        check("div_by_zero", div_by_zero, mon_e.dbz);
      end
    end
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    flush = 1'b0; hi_wr_en = 1'b0; lo_wr_en = 1'b0; wr_data = '0;
    last_hi = RST_VAL; last_lo = RST_VAL;

    // Asynchronous reset, observed before the first clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, RST_VAL);
    check("rst_lo", lo, RST_VAL);
    repeat (3) @(negedge clk);

    // First start offered as reset releases: taken at the very next edge. MULT -3 * 7.
    rst = 1'b0; start = 1'b1; op = 2'b01; src_a = 32'hFFFF_FFFD; src_b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("first_start_accepted", busy, 1);
    push_exp(2'b01, 32'hFFFF_FFFD, 32'd7);
    drain();
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFEB);

    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1);
    drain();
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    issue(2'b10, 32'd100, 32'd0, 1);
    drain();
    check("divu_zero_lo", lo, 32'hFFFF_FFFF);
    check("divu_zero_hi", hi, 32'd100);
    repeat (3) @(negedge clk);
    check("dbz_sticky", div_by_zero, 1);

    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    drain();
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0);
    check("div_ovf_dbz", div_by_zero, 0);

    // Flush at cycle 10 of a MULTU: aborted without touching hi/lo, restart next cycle.
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    check("flush_hi_kept", hi, last_hi);
    check("flush_lo_kept", lo, last_lo);
    issue(2'b00, 32'h0001_2345, 32'h0000_0ABC, 1);
    drain();

    // Flush together with start in IDLE: start must be ignored.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd6;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check("flush_blocks_start", busy, 0);

    // Back-to-back ops; start and HI writes while busy must be ignored.
    issue(2'b01, 32'h1234_5678, 32'h8765_4321, 1);
    repeat (5) begin
      @(negedge clk);
      start = 1'b1; op = 2'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom;
      hi_wr_en = 1'b1; lo_wr_en = 1'b1; wr_data = $urandom;
    end
    @(negedge clk);
    start = 1'b0; hi_wr_en = 1'b0; lo_wr_en = 1'b0;
    issue(2'b10, 32'hDEAD_BEEF, 32'h0000_1234, 1);
    issue(2'b11, 32'h8000_0001, 32'h0000_0003, 1);
    drain();

    // HI write accepted in the same cycle as a start.
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd11;
    hi_wr_en = 1'b1; wr_data = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    start = 1'b0; hi_wr_en = 1'b0;
    check("wr_with_start_busy", busy, 1);
    check("wr_with_start_hi", hi, 32'hCAFE_F00D);
    push_exp(2'b00, 32'd9, 32'd11);
    drain();

    // Reset in the middle of a MULTU discards it entirely.
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hi", hi, RST_VAL);
    check("midrst_lo", lo, RST_VAL);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    lo_wr_en = 1'b1; wr_data = 32'h0000_1234;
    @(posedge clk);
    #1;
    lo_wr_en = 1'b0;
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_hi_kept", hi, RST_VAL);

    // Randomized ops, issued back-to-back.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      issue(ro, ra, rb, 1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
